// File: rtl/hs_dpath_stream_upsizer.sv
// Narrow-to-wide stream packer: collects RATIO input beats (or fewer when
// in_last arrives early) into one wide output beat. The lowest lane holds the
// earliest beat. Lanes that were never written carry zero strobe bits.
module hs_dpath_stream_upsizer #(
  parameter int DATA_WIDTH  = 32,
  parameter int RATIO       = 4,
  parameter int STROBE_UNIT = 8,
  localparam int IN_STRB    = DATA_WIDTH / STROBE_UNIT,
  localparam int IDX_W      = $clog2(RATIO)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [IN_STRB-1:0]            in_strobe,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   out_data,
  output logic [IN_STRB*RATIO-1:0]      out_strobe,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready
);

  if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
    $fatal(1, "hs_dpath_stream_upsizer: RATIO must be within 2..16");
  end
  if (DATA_WIDTH % STROBE_UNIT != 0) begin : g_bad_width
    $fatal(1, "hs_dpath_stream_upsizer: DATA_WIDTH must be a multiple of STROBE_UNIT");
  end

  logic                        rst_done;
  logic [IDX_W-1:0]            idx;
  logic [DATA_WIDTH*RATIO-1:0] acc_data;
  logic [IN_STRB*RATIO-1:0]    acc_strobe;
  logic [DATA_WIDTH*RATIO-1:0] merged_data;
  logic [IN_STRB*RATIO-1:0]    merged_strobe;
  logic                        in_fire;
  logic                        completing;

  // A new output beat may only be loaded when the output register is free or
  // is being emptied in this very cycle, so the input stalls otherwise.
  assign in_ready   = rst_done & (~out_valid | out_ready);
  assign in_fire    = in_valid & in_ready;
  assign completing = in_fire & ((idx == IDX_W'(RATIO - 1)) | in_last);

  // Accumulator with the current input beat dropped into lane idx.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    merged_data   = acc_data;
    merged_strobe = acc_strobe;
    merged_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    merged_strobe[int'(idx)*IN_STRB +: IN_STRB]     = in_strobe;
  end

  // Control state: lane index, strobe accumulator and output handshake flags.
  always_ff @(posedge clk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      rst_done   <= 1'b0;
      idx        <= '0;
      acc_strobe <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_strobe <= '0;
    end else begin
      rst_done <= 1'b1;
      // Output handshake empties the register unless refilled below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_fire) begin
        if (completing) begin
          idx        <= '0;
          acc_strobe <= '0;
          out_valid  <= 1'b1;
          out_last   <= in_last;
          out_strobe <= merged_strobe;
        end else begin
          idx        <= idx + IDX_W'(1);
          acc_strobe <= merged_strobe;
        end
      end
    end
  end

  // Wide data path; lane validity is carried entirely by the strobes.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are deliberately left without reset: the
    // strobes and valid flag qualify them, so their power-up value is unused.
    if (in_fire) begin
      acc_data <= merged_data;
    end
    if (completing) begin
      out_data <= merged_data;
    end
  end

endmodule

// File: doc/hs_dpath_stream_upsizer.md
HS_DPATH_STREAM_UPSIZER -- requirements
Module: hs_dpath_stream_upsizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: input beat width in bits; legal when a multiple of STROBE_UNIT.
REQ-002 SHALL have parameter RATIO, default 4: input beats packed per output beat; legal range 2..16.
REQ-003 SHALL have parameter STROBE_UNIT, default 8: bits per strobe lane.
REQ-004 SHALL have local parameter IN_STRB = DATA_WIDTH/STROBE_UNIT and local parameter IDX_W = $clog2(RATIO); neither is overridable.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports in_data (input, DATA_WIDTH), in_strobe (input, IN_STRB), in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): narrow input stream.
REQ-008 SHALL have ports out_data (output, DATA_WIDTH*RATIO), out_strobe (output, IN_STRB*RATIO), out_valid (output, 1), out_last (output, 1) and out_ready (input, 1): wide output stream.

Function
REQ-009 SHALL transfer a beat only in a cycle where valid and ready are both high on the same side.
REQ-010 SHALL hold a lane index idx (IDX_W bits) and accumulator registers acc_data and acc_strobe.
REQ-011 SHALL write an accepted input beat into lane idx, which occupies data bits [idx*DATA_WIDTH +: DATA_WIDTH] and strobe bits [idx*IN_STRB +: IN_STRB]; lane 0 is the least significant.
REQ-012 SHALL treat an accepted beat as completing when idx == RATIO-1 or in_last = 1.
REQ-013 On a non-completing accept, SHALL increment idx by 1.
REQ-014 On a completing accept, in the next cycle SHALL present the following on the output registers: the accumulator merged with the current lane, out_valid = 1, and out_last = in_last.
REQ-015 On a completing accept, SHALL reset idx to 0 and clear acc_strobe to 0 in the same cycle as REQ-014.
REQ-016 SHALL drive out_strobe = 0 for lanes not written since the last completion; the contents of out_data in those lanes are don't-care.
REQ-017 SHALL treat an input beat with in_strobe = 0 as occupying its lane; such a beat SHALL still advance idx.
REQ-018 SHALL compute in_ready = rst_done AND (NOT out_valid OR out_ready).
REQ-019 SHALL sustain one input beat per cycle when out_ready is held at 1.
REQ-020 SHALL have latency of 1 cycle from the completing input accept to out_valid.
REQ-021 While out_valid = 1 and out_ready = 0, SHALL hold out_data, out_strobe and out_last stable.
REQ-022 On a simultaneous output handshake and completing input accept, SHALL load the new output beat in the next cycle and keep out_valid = 1, with no bubble cycle.
REQ-023 On an output handshake with no completing accept in the same cycle, SHALL drive out_valid = 0 in the next cycle.
REQ-024 SHALL never drop, duplicate or reorder an input beat.
REQ-025 A beat with in_last = 1 accepted at idx = 0 SHALL produce one output beat carrying only lane 0 strobe bits and out_last = 1.

Reset
REQ-026 While aresetn = 0, SHALL drive out_valid = 0, out_last = 0, out_strobe = 0, idx = 0, acc_strobe = 0, rst_done = 0 and in_ready = 0.
REQ-027 SHALL set rst_done to 1 on the first rising edge of clk after aresetn deasserts.
REQ-028 SHALL clear acc_data and out_data at reset only when the data path is synthesised with reset flops; their value after reset is otherwise don't-care.
REQ-029 An assertion of aresetn mid-packet SHALL discard the partial accumulator and any pending output beat; the first beat accepted after reset SHALL land in lane 0.

Structure
REQ-030 SHALL take no typedefs from any package and SHALL define no new shared package.
REQ-031 SHALL elaborate with $fatal when RATIO < 2, when RATIO > 16, or when DATA_WIDTH % STROBE_UNIT != 0.
REQ-032 SHALL contain no sub-module; its output SHALL be directly connectable to hs_dpath_skid_buffer with DATA_TYPE = logic [DATA_WIDTH*RATIO-1:0] and the same STROBE_UNIT.
REQ-033 SHALL keep the implementation within approximately 150 to 250 lines.

Verification
REQ-034 Bench SHALL cover streaming, with DATA_WIDTH=32, RATIO=4, out_ready held 1: inputs 0x11111111..0x88888888 with strobe 0xF and in_last on the 8th beat -> out_data 0x44444444_33333333_22222222_11111111 then 0x88888888_77777777_66666666_55555555; out_last = 1 on the second beat only; in_ready stays 1.
REQ-035 Bench SHALL cover short packet: three beats with in_last on the 3rd -> out_strobe = 0x0FFF and out_last = 1.
REQ-036 Bench SHALL cover single-beat packet: one beat 0xDEADBEEF with in_last -> out_strobe = 0x000F, out_data[31:0] = 0xDEADBEEF, out_last = 1.
REQ-037 Bench SHALL cover backpressure: hold out_ready = 0 for 5 cycles with out_valid = 1 -> in_ready = 0 and the output stable for those cycles; on release, the next packet completes with no loss.
REQ-038 Bench SHALL cover reset mid-operation: assert aresetn after 2 accepted beats -> out_valid = 0 and in_ready = 0 during reset; the next 4 beats after reset yield a single output with all 16 strobe bits set.
REQ-039 Bench SHALL cover random valid/ready toggling over 10k beats against a scoreboard -> zero mismatches and one output per RATIO input beats or per in_last.
